cic_comp_fir: RTL and testbench
===============================

// Module: cic_comp_fir
// PURPOSE
//  Compensation FIR directly downstream of the multi-stage CIC decimator: consumes the 17-bit decimated
//  output and its one-cycle valid strobe, flattens CIC passband droop with a symmetric 7-tap filter.
//  One folded (pre-add) multiply-accumulate per clock; output is rounded and range-limited to 17 bits.
// PARAMETERS
//  NTAP      7   tap count, odd, symmetric; must equal length of COEF in cic_comp_pkg
//  DIN_W     17  input sample width, signed
//  COEF_W    12  coefficient width, signed
//  COEF_FRAC 10  coefficient fractional bits (Q1.10, DC gain 1024 = 1.0)
//  OUT_W     17  output sample width, signed
// PORTS
//  clk       in   1      system clock, same clock as the CIC chain
//  rst       in   1      reset, synchronous, active-low
//  din       in   DIN_W  decimated CIC sample, signed
//  din_vld   in   1      one-cycle strobe, din valid (driven by CIC rdy)
//  dout      out  OUT_W  filtered sample, signed, held between strobes
//  dout_vld  out  1      one-cycle strobe, dout updated
//  busy      out  1      high while MAC sequence in progress (not IDLE)
//  overrun   out  1      sticky: a din_vld arrived while busy; cleared only by reset
// BEHAVIOUR
//  Reset (rst low at clk edge): delay line x[0..NTAP-1]=0, acc=0, dout=0, dout_vld=0, busy=0, overrun=0, state=IDLE.
//  FSM IDLE -> MAC -> OUT -> IDLE.  H = (NTAP+1)/2 = 4.
//   IDLE: din_vld=1 -> x shifts (x[0]<=din, x[k]<=x[k-1]), acc<=0, k<=0, go MAC.
//   MAC : per cycle acc += (x[k]+x[NTAP-1-k])*COEF[k] for k<H-1; k=H-1 (centre) acc += x[k]*COEF[k]; after H cycles go OUT.
//   OUT : dout <= lim((acc + 2^(COEF_FRAC-1)) >>> COEF_FRAC); dout_vld=1 for this one cycle; go IDLE.
//  Latency: din_vld sampled at edge E0 -> dout_vld high in the cycle after edge E0+H+1 (6 clocks for NTAP=7).
//  Min din_vld spacing H+2 = 6 clocks; CIC decimated rate is far slower.
//  din_vld while busy (MAC or OUT): sample dropped, delay line untouched, overrun<=1; running result unaffected.
//  din_vld in the same cycle OUT->IDLE transition: treated as busy (dropped); accepted from IDLE only.
//  Widths: pre-add DIN_W+1=18, product 30, acc 32 (product + ceil(log2 H)); no internal overflow possible.
//  Rounding: add half-LSB then arithmetic shift (round half toward +inf).
//  Reset mid-operation: sequence abandoned, no dout_vld, history cleared; next accepted sample sees zero history.
// CONFIGURATION
//  CIC_COMP_SAT_EN defined: lim() saturates to [-2^(OUT_W-1), 2^(OUT_W-1)-1] = [-65536, 65535].
//  CIC_COMP_SAT_EN undefined: lim() keeps low OUT_W bits (two's-complement wrap); no saturation logic built.
// STRUCTURE
//  cic_comp_pkg: COEF array {-16,48,-176,1312,-176,48,-16} (sum 1024), NTAP, COEF_W, COEF_FRAC, ACC_W, state enum.
//  Sub-module cic_comp_mac: pre-adder, multiplier, accumulator with clear/enable; FSM, delay line, rounding/limit stay in top.
// TESTING
//  Reset: hold rst low 3 clocks with din_vld pulsing -> dout=0, dout_vld=0, busy=0, overrun=0 throughout.
//  Impulse: din=1024 once then 0, strobes every 10 clocks -> dout sequence -16,48,-176,1312,-176,48,-16, then 0.
//  DC: din=1000 every 10 clocks -> from 7th output on dout=1000; each dout_vld exactly 6 clocks after its din_vld.
//  Saturation: alternate din=+65535/-65536 -> with CIC_COMP_SAT_EN dout clamps to 65535/-65536; without, wrapped values match model.
//  Overrun: din_vld pulses 3 clocks apart -> second sample dropped, overrun=1 and stays 1; first result unchanged.
//  Reset mid-MAC: rst low 1 clock during MAC -> no dout_vld; next impulse 1024 yields -16 first (zero history).

Source files
------------

// File: rtl/cic_comp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : cic_comp_pkg                                                   |
// | Brief   : Shared constants, coefficients and FSM encoding for the CIC    |
// |           compensation FIR.                                              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package cic_comp_pkg;

    localparam int NTAP      = 7;
    localparam int DIN_W     = 17;
    localparam int COEF_W    = 12;
    localparam int COEF_FRAC = 10;
    localparam int OUT_W     = 17;
    localparam int ACC_W     = DIN_W + 1 + COEF_W + $clog2((NTAP + 1) / 2);

    // Symmetric droop-compensation taps, Q1.10, sum 1024 (unity DC gain)
    localparam logic signed [COEF_W-1:0] COEF [NTAP] = '{
        -12'sd16, 12'sd48, -12'sd176, 12'sd1312, -12'sd176, 12'sd48, -12'sd16
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cic_comp_mac.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : cic_comp_mac                                                   |
// | Brief   : Folded pre-add, multiply and accumulate datapath with          |
// |           synchronous clear and enable.                                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cic_comp_mac #(
    parameter int DIN_W  = cic_comp_pkg::DIN_W,
    parameter int COEF_W = cic_comp_pkg::COEF_W,
    parameter int ACC_W  = cic_comp_pkg::ACC_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clr,
    input  logic                     i_en,
    input  logic                     i_centre,
    input  logic signed [DIN_W-1:0]  i_xa,
    input  logic signed [DIN_W-1:0]  i_xb,
    input  logic signed [COEF_W-1:0] i_coef,
    output logic signed [ACC_W-1:0]  o_acc
);

    localparam int c_pre_w  = DIN_W + 1;
    localparam int c_prod_w = c_pre_w + COEF_W;

    logic signed [c_pre_w-1:0]  w_xa_ext;
    logic signed [c_pre_w-1:0]  w_xb_ext;
    logic signed [c_pre_w-1:0]  w_pre;
    logic signed [c_prod_w-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_prod_ext;
    logic signed [ACC_W-1:0]    r_acc;

    // The centre tap has no mirror partner, so it bypasses the pre-adder
    always_comb begin
        w_xa_ext   = {i_xa[DIN_W-1], i_xa};
        w_xb_ext   = {i_xb[DIN_W-1], i_xb};
        w_pre      = i_centre ? w_xa_ext : (w_xa_ext + w_xb_ext);
        w_prod     = w_pre * i_coef;
        w_prod_ext = {{(ACC_W - c_prod_w){w_prod[c_prod_w-1]}}, w_prod};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + w_prod_ext;
        end
    end

    assign o_acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/cic_comp_fir.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : cic_comp_fir                                                   |
// | Brief   : 7-tap symmetric CIC droop compensation FIR, one folded MAC     |
// |           per clock, rounded and range-limited 17-bit output.            |
// |           Define CIC_COMP_SAT_EN to saturate the output, else it wraps.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cic_comp_fir #(
    parameter int NTAP      = cic_comp_pkg::NTAP,
    parameter int DIN_W     = cic_comp_pkg::DIN_W,
    parameter int COEF_W    = cic_comp_pkg::COEF_W,
    parameter int COEF_FRAC = cic_comp_pkg::COEF_FRAC,
    parameter int OUT_W     = cic_comp_pkg::OUT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [DIN_W-1:0] din,
    input  logic                    din_vld,
    output logic signed [OUT_W-1:0] dout,
    output logic                    dout_vld,
    output logic                    busy,
    output logic                    overrun
);

    import cic_comp_pkg::*;

    localparam int c_half  = (NTAP + 1) / 2;
    localparam int c_kw    = $clog2(NTAP);
    localparam int c_acc_w = DIN_W + 1 + COEF_W + $clog2(c_half);

    localparam logic signed [c_acc_w-1:0] c_rnd = c_acc_w'(2 ** (COEF_FRAC - 1));
`ifdef CIC_COMP_SAT_EN
    localparam logic signed [c_acc_w-1:0] c_max = c_acc_w'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [c_acc_w-1:0] c_min = -c_acc_w'(2 ** (OUT_W - 1));
`endif

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [c_kw-1:0]           r_k;
    logic signed [DIN_W-1:0]   r_x [NTAP];
    logic signed [OUT_W-1:0]   r_dout;
    logic                      r_dout_vld;
    logic                      r_overrun;

    logic                      w_accept;
    logic                      w_clr;
    logic                      w_en;
    logic                      w_centre;
    logic                      w_fire;
    logic                      w_busy;
    logic signed [DIN_W-1:0]   w_xa;
    logic signed [DIN_W-1:0]   w_xb;
    logic signed [COEF_W-1:0]  w_coef;
    logic signed [c_acc_w-1:0] w_acc;
    logic signed [c_acc_w-1:0] w_rnd;
    logic signed [OUT_W-1:0]   w_lim;

    assign w_busy = (r_state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Samples are accepted only from IDLE; anything else is dropped
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_clr       = 1'b0;
        w_en        = 1'b0;
        w_centre    = 1'b0;
        w_fire      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (din_vld) begin
                    w_accept    = 1'b1;
                    w_clr       = 1'b1;
                    w_state_nxt = ST_MAC;
                end
            end
            ST_MAC: begin
                w_en     = 1'b1;
                w_centre = (r_k == c_kw'(c_half - 1));
                if (w_centre) begin
                    w_state_nxt = ST_OUT;
                end
            end
            ST_OUT: begin
                w_fire      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NTAP; i++) begin
                r_x[i] <= '0;
            end
        end else if (w_accept) begin
            r_x[0] <= din;
            for (int i = 1; i < NTAP; i++) begin
                r_x[i] <= r_x[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_k <= '0;
        end else if (w_clr) begin
            r_k <= '0;
        end else if (w_en) begin
            r_k <= r_k + 1'b1;
        end
    end

    assign w_xa   = r_x[r_k];
    assign w_xb   = r_x[c_kw'(NTAP - 1) - r_k];
    assign w_coef = COEF[r_k];

    cic_comp_mac #(
        .DIN_W  (DIN_W),
        .COEF_W (COEF_W),
        .ACC_W  (c_acc_w)
    ) u_mac (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_clr),
        .i_en     (w_en),
        .i_centre (w_centre),
        .i_xa     (w_xa),
        .i_xb     (w_xb),
        .i_coef   (w_coef),
        .o_acc    (w_acc)
    );

    // Half-LSB bias then arithmetic shift: round half toward +inf
    assign w_rnd = (w_acc + c_rnd) >>> COEF_FRAC;

`ifdef CIC_COMP_SAT_EN
    always_comb begin
        if (w_rnd > c_max) begin
            w_lim = OUT_W'(c_max);
        end else if (w_rnd < c_min) begin
            w_lim = OUT_W'(c_min);
        end else begin
            w_lim = OUT_W'(w_rnd);
        end
    end
`else
    assign w_lim = OUT_W'(w_rnd);
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_dout     <= '0;
            r_dout_vld <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_dout_vld <= w_fire;
            if (w_fire) begin
                r_dout <= w_lim;
            end
            if (din_vld && w_busy) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign dout     = r_dout;
    assign dout_vld = r_dout_vld;
    assign busy     = w_busy;
    assign overrun  = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_cic_comp_fir.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_cic_comp_fir                                                |
// | Brief   : Directed self-checking bench for cic_comp_fir; expectations    |
// |           follow CIC_COMP_SAT_EN when it is defined.                     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_cic_comp_fir;

    logic               clk     = 1'b0;
    logic               rst     = 1'b0;
    logic signed [16:0] din     = '0;
    logic               din_vld = 1'b0;
    logic signed [16:0] dout;
    logic               dout_vld;
    logic               busy;
    logic               overrun;

    int checks   = 0;
    int failures = 0;

    cic_comp_fir dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .din_vld  (din_vld),
        .dout     (dout),
        .dout_vld (dout_vld),
        .busy     (busy),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    // One strobe, then a 10-clock window watching for the result
    task automatic strobe(input logic signed [16:0] v, output logic signed [16:0] got,
                          output int lat, output int npulse);
        @(negedge clk);
        din     = v;
        din_vld = 1'b1;
        @(negedge clk);
        din_vld = 1'b0;
        din     = '0;
        lat     = -1;
        got     = '0;
        npulse  = 0;
        for (int c = 1; c <= 10; c++) begin
            if (dout_vld) begin
                npulse++;
                if (lat < 0) begin
                    lat = c;
                    got = dout;
                end
            end
            if (c < 10) @(negedge clk);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            din     = 17'sd777;
            din_vld = (c != 1);
            checks++;
            if ({dout, dout_vld, busy, overrun} !== 20'd0) begin
                failures++;
                $display("FAIL reset_outputs cycle=%0d: dout=%0d vld=%b busy=%b ovr=%b, need all 0",
                         c, dout, dout_vld, busy, overrun);
            end
        end
        @(negedge clk);
        din_vld = 1'b0;
        din     = '0;
        rst     = 1'b1;
        @(negedge clk);
        checks++;
        if ({dout_vld, busy, overrun} !== 3'b000) begin
            failures++;
            $display("FAIL reset_release: vld=%b busy=%b ovr=%b, need 000", dout_vld, busy, overrun);
        end
    endtask

    task automatic test_impulse();
        int exp_v [8] = '{-16, 48, -176, 1312, -176, 48, -16, 0};
        logic signed [16:0] got;
        int lat, np;
        for (int i = 0; i < 8; i++) begin
            strobe((i == 0) ? 17'sd1024 : 17'sd0, got, lat, np);
            checks++;
            if (lat !== 6 || np !== 1) begin
                failures++;
                $display("FAIL impulse_latency idx=%0d: lat=%0d pulses=%0d, need lat=6 pulses=1", i, lat, np);
            end
            checks++;
            if (got !== 17'(exp_v[i])) begin
                failures++;
                $display("FAIL impulse_value idx=%0d: got %0d, need %0d", i, got, exp_v[i]);
            end
            checks++;
            if (dout !== 17'(exp_v[i])) begin
                failures++;
                $display("FAIL impulse_hold idx=%0d: dout %0d, need %0d", i, dout, exp_v[i]);
            end
        end
    endtask

    task automatic test_dc();
        logic signed [16:0] got;
        int lat, np;
        for (int i = 0; i < 8; i++) begin
            strobe(17'sd1000, got, lat, np);
            checks++;
            if (lat !== 6 || np !== 1) begin
                failures++;
                $display("FAIL dc_latency idx=%0d: lat=%0d pulses=%0d, need lat=6 pulses=1", i, lat, np);
            end
            if (i == 0) begin
                checks++;
                if (got !== -17'sd16) begin
                    failures++;
                    $display("FAIL dc_first: got %0d, need -16", got);
                end
            end else if (i == 1) begin
                checks++;
                if (got !== 17'sd31) begin
                    failures++;
                    $display("FAIL dc_second: got %0d, need 31", got);
                end
            end else if (i >= 6) begin
                checks++;
                if (got !== 17'sd1000) begin
                    failures++;
                    $display("FAIL dc_settled idx=%0d: got %0d, need 1000", i, got);
                end
            end
        end
    endtask

    task automatic test_saturation();
        logic signed [16:0] got;
        logic signed [16:0] exp_even;
        logic signed [16:0] exp_odd;
        int lat, np;
`ifdef CIC_COMP_SAT_EN
        exp_even = -17'sd65536;
        exp_odd  = 17'sd65535;
`else
        exp_even = 17'sd16384;
        exp_odd  = -17'sd16385;
`endif
        for (int i = 0; i < 8; i++) begin
            strobe((i % 2 == 0) ? 17'sd65535 : -17'sd65536, got, lat, np);
            if (i >= 6) begin
                checks++;
                if (lat !== 6 || got !== ((i % 2 == 0) ? exp_even : exp_odd)) begin
                    failures++;
                    $display("FAIL sat_value idx=%0d: got %0d lat=%0d, need %0d lat=6",
                             i, got, lat, (i % 2 == 0) ? exp_even : exp_odd);
                end
            end
        end
    endtask

    task automatic test_overrun();
        logic signed [16:0] got;
        int lat, np;
        apply_reset();
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL overrun_clear: overrun=%b, need 0", overrun);
        end
        @(negedge clk);
        din     = 17'sd1024;
        din_vld = 1'b1;
        @(negedge clk);
        din_vld = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL overrun_busy: busy=%b, need 1", busy);
        end
        @(negedge clk);
        @(negedge clk);
        din     = 17'sd5000;
        din_vld = 1'b1;
        @(negedge clk);
        din_vld = 1'b0;
        din     = '0;
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_set: overrun=%b, need 1", overrun);
        end
        lat = -1;
        got = '0;
        for (int c = 4; c <= 10; c++) begin
            if (dout_vld && lat < 0) begin
                lat = c;
                got = dout;
            end
            if (c < 10) @(negedge clk);
        end
        checks++;
        if (lat !== 6 || got !== -17'sd16) begin
            failures++;
            $display("FAIL overrun_first_result: got %0d lat=%0d, need -16 lat=6", got, lat);
        end
        strobe(17'sd0, got, lat, np);
        checks++;
        if (got !== 17'sd48) begin
            failures++;
            $display("FAIL overrun_history: got %0d, need 48", got);
        end
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_sticky: overrun=%b, need 1", overrun);
        end
    endtask

    task automatic test_reset_mid();
        logic signed [16:0] got;
        int lat, np;
        @(negedge clk);
        din     = 17'sd2000;
        din_vld = 1'b1;
        @(negedge clk);
        din_vld = 1'b0;
        din     = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checks++;
        if ({dout, busy, overrun} !== 19'd0) begin
            failures++;
            $display("FAIL midreset_state: dout=%0d busy=%b ovr=%b, need 0 0 0", dout, busy, overrun);
        end
        np = 0;
        for (int c = 0; c < 10; c++) begin
            if (dout_vld) np++;
            @(negedge clk);
        end
        checks++;
        if (np !== 0) begin
            failures++;
            $display("FAIL midreset_no_output: pulses=%0d, need 0", np);
        end
        strobe(17'sd1024, got, lat, np);
        checks++;
        if (got !== -17'sd16 || lat !== 6) begin
            failures++;
            $display("FAIL midreset_zero_history: got %0d lat=%0d, need -16 lat=6", got, lat);
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_dc();
        test_saturation();
        test_overrun();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
